// File: rtl/instr_fetch_unit_pkg.sv
// +--------------------------------------------------------------------+
// | Module : instr_fetch_unit_pkg                                      |
// | Brief  : Shared opcodes, instruction field positions and FSM state |
// |          encoding for the instruction fetch unit.                  |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
`default_nettype none

package instr_fetch_unit_pkg;

  // Opcode map (IR[15:12])
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1000;
  localparam logic [3:0] OP_LD  = 4'b1001;
  localparam logic [3:0] OP_ST  = 4'b1010;
  localparam logic [3:0] OP_MOV = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_BEQ = 4'b1101;
  localparam logic [3:0] OP_BNE = 4'b1110;
  localparam logic [3:0] OP_NOP = 4'b1111;

  // Instruction field bit positions
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int RD_MSB   = 11;
  localparam int RD_LSB   = 8;
  localparam int RS1_MSB  = 7;
  localparam int RS1_LSB  = 4;
  localparam int RS2_MSB  = 3;
  localparam int RS2_LSB  = 0;
  localparam int IMM8_MSB = 7;
  localparam int IMM8_LSB = 0;

  // Fetch FSM state encoding
  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2
  } ifu_state_e;

endpackage

`default_nettype wire

// File: rtl/ifu_next_pc.sv
// +--------------------------------------------------------------------+
// | Module : ifu_next_pc                                               |
// | Brief  : Combinational next-PC select: jump, taken branch, or      |
// |          sequential, in that priority. 16-bit modulo arithmetic.   |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module ifu_next_pc (
  input  logic [15:0] pc_i,
  input  logic [11:0] ir_lo_i,
  input  logic        pc_write_i,
  input  logic        branch_eq_i,
  input  logic        branch_ne_i,
  input  logic        zero_flag_i,
  output logic [15:0] next_pc_o
);

  logic [15:0] seq_pc;
  logic [15:0] br_off;
  logic        br_taken;

  assign seq_pc   = pc_i + 16'd1;
  assign br_off   = {{8{ir_lo_i[7]}}, ir_lo_i[7:0]};
  assign br_taken = (branch_eq_i & zero_flag_i) | (branch_ne_i & ~zero_flag_i);

  // Jump target keeps the current 4K page; branch is relative to pc+1
  always_comb begin
    next_pc_o = seq_pc;
    if (pc_write_i) begin
      next_pc_o = {pc_i[15:12], ir_lo_i};
    end else if (br_taken) begin
      next_pc_o = seq_pc + br_off;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// +--------------------------------------------------------------------+
// | Module : instr_fetch_unit                                          |
// | Brief  : Fetch stage: owns the PC, fetches over req/ack into the   |
// |          IR, presents decode fields, applies redirects on          |
// |          exec_done. Optional performance counters are enabled by   |
// |          defining IFU_PERF_CNT_EN.                                 |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  output logic [3:0]  opcode,
  output logic [3:0]  rd,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [7:0]  imm8,
  input  logic        exec_done,
  input  logic        pc_write,
  input  logic        branch_eq,
  input  logic        branch_ne,
  input  logic        zero_flag,
  output logic [15:0] pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
`endif
);

  ifu_state_e  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        req_q, req_d;
  logic [15:0] next_pc;

  ifu_next_pc u_next_pc (
    .pc_i        (pc_q),
    .ir_lo_i     (ir_q[11:0]),
    .pc_write_i  (pc_write),
    .branch_eq_i (branch_eq),
    .branch_ne_i (branch_ne),
    .zero_flag_i (zero_flag),
    .next_pc_o   (next_pc)
  );

  // State, PC, IR and request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
    end
  end

  // Next-state logic; a raised request is held until ack regardless of halt
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    req_d   = req_q;
    case (state_q)
      ST_FETCH: begin
        if (req_q) begin
          if (imem_ack) begin
            ir_d    = imem_rdata;
            req_d   = 1'b0;
            state_d = ST_DECODE;
          end
        end else if (!halt) begin
          req_d = 1'b1;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (exec_done) begin
          pc_d    = next_pc;
          // Issue the next request straight away so an immediate ack gives 3 cycles/instr
          req_d   = ~halt;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_FETCH;
        req_d   = 1'b0;
      end
    endcase
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_valid = (state_q == ST_DECODE);
  assign opcode      = ir_q[OPC_MSB:OPC_LSB];
  assign rd          = ir_q[RD_MSB:RD_LSB];
  assign rs1         = ir_q[RS1_MSB:RS1_LSB];
  assign rs2         = ir_q[RS2_MSB:RS2_LSB];
  assign imm8        = ir_q[IMM8_MSB:IMM8_LSB];

`ifdef IFU_PERF_CNT_EN
  logic [31:0] retired_q;
  logic [31:0] stall_q;

  // Retired-instruction and fetch-stall counters, free-running with wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= 32'd0;
      stall_q   <= 32'd0;
    end else begin
      if ((state_q == ST_EXEC) && exec_done) begin
        retired_q <= retired_q + 32'd1;
      end
      if ((state_q == ST_FETCH) && ((req_q && !imem_ack) || halt)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// +--------------------------------------------------------------------+
// | Module : tb_instr_fetch_unit                                       |
// | Brief  : Self-checking bench for instr_fetch_unit: scoreboarded    |
// |          fetch addresses and decode fields against a PC model.     |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_instr_fetch_unit;

  localparam logic [15:0] RST_PC = 16'h0010;

  logic        clk;
  logic        rst_n;
  logic        halt;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [3:0]  opcode, rd, rs1, rs2;
  logic [7:0]  imm8;
  logic        exec_done, pc_write, branch_eq, branch_ne, zero_flag;
  logic [15:0] pc;

  int tests = 0;
  int fails = 0;
  bit abort = 0;

  logic [15:0] exp_addr_q[$];
  logic [15:0] exp_ir_q[$];
  logic [15:0] mpc;
  logic [15:0] mon_e;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .imm8        (imm8),
    .exec_done   (exec_done),
    .pc_write    (pc_write),
    .branch_eq   (branch_eq),
    .branch_ne   (branch_ne),
    .zero_flag   (zero_flag),
    .pc          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference PC rule, written with plain integer arithmetic
  function automatic logic [15:0] model_next(input logic [15:0] cur, input logic [15:0] ir,
                                             input bit pcw, input bit beq, input bit bne,
                                             input bit zf);
    int np;
    int off;
    off = int'(ir) % 256;
    if (off >= 128) off = off - 256;
    if (pcw) np = (int'(cur) / 4096) * 4096 + int'(ir) % 4096;
    else if ((beq && zf) || (bne && !zf)) np = int'(cur) + 1 + off;
    else np = int'(cur) + 1;
    np = (np + 65536) % 65536;
    return np[15:0];
  endfunction

  // Monitor: compares fetch address on each handshake and decode fields on each valid
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req && imem_ack) begin
        tests++;
        if (exp_addr_q.size() == 0) begin
          fails++;
          $display("FAIL fetch_addr: unexpected fetch at %h", imem_addr);
        end else begin
          mon_e = exp_addr_q.pop_front();
          if (imem_addr !== mon_e) begin
            fails++;
            $display("FAIL fetch_addr: got %h expected %h", imem_addr, mon_e);
          end
        end
      end
      if (instr_valid) begin
        if (exp_ir_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL instr_valid: unexpected pulse, opcode %h", opcode);
        end else begin
          mon_e = exp_ir_q.pop_front();
          check("opcode", {28'd0, opcode}, {28'd0, mon_e[15:12]});
          check("rd",     {28'd0, rd},     {28'd0, mon_e[11:8]});
          check("rs1",    {28'd0, rs1},    {28'd0, mon_e[7:4]});
          check("rs2",    {28'd0, rs2},    {28'd0, mon_e[3:0]});
          check("imm8",   {24'd0, imm8},   {24'd0, mon_e[7:0]});
        end
      end
    end
  end

  task automatic do_instr(input logic [15:0] instr, input int ackdly, input bit pcw,
                          input bit beq, input bit bne, input bit zf, input int execdly,
                          input int haltc, input bit early_done);
    int n;
    logic [15:0] a0;
    logic [15:0] np;
    if (abort) return;
    n = 0;
    while (!imem_req && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!imem_req) begin
      tests++;
      fails++;
      $display("FAIL req_timeout: imem_req %b after %0d cycles", imem_req, n);
      abort = 1;
      return;
    end
    a0 = imem_addr;
    for (int i = 0; i < ackdly; i++) begin
      halt = ($urandom_range(0, 2) == 0);
      @(posedge clk); #1;
      check("req_hold",  {31'd0, imem_req}, 32'd1);
      check("addr_hold", {16'd0, imem_addr}, {16'd0, a0});
    end
    halt       = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = instr;
    exp_ir_q.push_back(instr);
    @(posedge clk); #1;
    imem_ack   = 1'b0;
    imem_rdata = 16'($urandom);
    // Decode cycle: an exec_done here must be ignored
    if (early_done) begin
      exec_done = 1'b1;
      pc_write  = 1'b1;
    end
    @(posedge clk); #1;
    exec_done = 1'b0;
    pc_write  = 1'b0;
    for (int i = 0; i < execdly; i++) begin
      @(posedge clk); #1;
      check("no_req_exec", {31'd0, imem_req}, 32'd0);
    end
    pc_write  = pcw;
    branch_eq = beq;
    branch_ne = bne;
    zero_flag = zf;
    exec_done = 1'b1;
    halt      = (haltc > 0);
    np  = model_next(mpc, instr, pcw, beq, bne, zf);
    mpc = np;
    exp_addr_q.push_back(np);
    @(posedge clk); #1;
    exec_done = 1'b0;
    pc_write  = 1'b0;
    branch_eq = 1'b0;
    branch_ne = 1'b0;
    zero_flag = 1'b0;
    check("pc_after_exec", {16'd0, pc}, {16'd0, np});
    if (haltc > 0) begin
      for (int i = 0; i < haltc; i++) begin
        check("halt_no_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk); #1;
      end
      halt = 1'b0;
      check("halt_no_req", {31'd0, imem_req}, 32'd0);
      @(posedge clk); #1;
      check("req_after_halt", {31'd0, imem_req}, 32'd1);
    end else begin
      check("req_next_cycle", {31'd0, imem_req}, 32'd1);
      check("addr_next_cycle", {16'd0, imem_addr}, {16'd0, np});
    end
  endtask

  initial begin
    #1000000;
    tests++;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    rst_n      = 1'b0;
    halt       = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    exec_done  = 1'b0;
    pc_write   = 1'b0;
    branch_eq  = 1'b0;
    branch_ne  = 1'b0;
    zero_flag  = 1'b0;
    mpc        = RST_PC;
    exp_addr_q.push_back(RST_PC);
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc",     {16'd0, pc},       {16'd0, RST_PC});
    check("rst_req",    {31'd0, imem_req}, 32'd0);
    check("rst_valid",  {31'd0, instr_valid}, 32'd0);
    check("rst_opcode", {28'd0, opcode},   32'd0);
    rst_n = 1'b1;
    // Halt held after reset: no request
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("halt_after_rst", {31'd0, imem_req}, 32'd0);
    end
    halt = 1'b0;
    @(posedge clk); #1;
    check("req_after_unhalt", {31'd0, imem_req}, 32'd1);
    check("addr_reset_pc",    {16'd0, imem_addr}, {16'd0, RST_PC});

    // Directed: immediate ack, delayed ack, wrap, jump priority, branches
    do_instr(16'h0123, 0, 0, 0, 0, 0, 0, 0, 0);  // 0x0010 -> 0x0011
    do_instr(16'h2456, 3, 0, 0, 0, 0, 1, 0, 0);  // -> 0x0012
    do_instr(16'hD0EC, 0, 0, 1, 0, 1, 0, 0, 0);  // beq taken -> 0xFFFF
    do_instr(16'h0000, 1, 0, 0, 0, 0, 0, 0, 0);  // 0xFFFF wraps -> 0x0000
    do_instr(16'hC123, 0, 1, 0, 1, 0, 0, 0, 1);  // jump beats bne -> 0x0123
    do_instr(16'hF000, 2, 0, 0, 0, 0, 0, 2, 0);  // NOP sequential -> 0x0124
    do_instr(16'hD0FE, 0, 0, 1, 0, 0, 0, 0, 0);  // beq not taken -> 0x0125
    do_instr(16'hD0FE, 0, 0, 1, 0, 1, 2, 0, 0);  // beq taken -> 0x0124

    // Randomized instruction stream
    for (int k = 0; k < 60; k++) begin
      do_instr(16'($urandom), $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
               1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
               ($urandom_range(0, 4) == 0));
    end

    // Reset during a pending request, with an ack arriving inside reset
    if (!abort) begin
      for (int i = 0; i < 10 && !imem_req; i++) begin
        @(posedge clk); #1;
      end
      #2;
      rst_n    = 1'b0;
      imem_ack = 1'b1;
      #1;
      check("midrst_req", {31'd0, imem_req}, 32'd0);
      check("midrst_pc",  {16'd0, pc},       {16'd0, RST_PC});
      exp_addr_q.delete();
      exp_ir_q.delete();
      mpc = RST_PC;
      exp_addr_q.push_back(RST_PC);
      @(posedge clk); #1;
      imem_ack = 1'b0;
      check("midrst_valid", {31'd0, instr_valid}, 32'd0);
      rst_n = 1'b1;
      do_instr(16'h1234, 1, 0, 0, 0, 0, 0, 0, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("ir_queue_drained", exp_ir_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
